planificador_ascensor: RTL and testbench

Elevator scheduling controller for the five-stop car (PS, P1–P4). It consumes the latched floor calls from the request register plus the synchronized floor, door and overweight sensors. It drives the hoist motor (up/down), the door actuator and the per-floor clear pulses back into the request register. It implements collective (SCAN) service: keep direction while calls remain ahead, reverse otherwise.

---
 rtl/planificador_ascensor_pkg.sv | 21 ++
 rtl/planificador_ascensor_temporizador_puerta.sv | 31 +++
 rtl/planificador_ascensor.sv | 167 ++++++++++++++++
 tb/tb_planificador_ascensor.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/planificador_ascensor_pkg.sv
// Shared constants for the five-stop elevator scheduler.
// State codes, floor numbers and sweep directions.
package planificador_ascensor_pkg;

  localparam logic [1:0] REPOSO   = 2'd0;
  localparam logic [1:0] SUBIENDO = 2'd1;
  localparam logic [1:0] BAJANDO  = 2'd2;
  localparam logic [1:0] PUERTA   = 2'd3;

  localparam logic [2:0] PISO_PS = 3'd0;
  localparam logic [2:0] PISO_P1 = 3'd1;
  localparam logic [2:0] PISO_P2 = 3'd2;
  localparam logic [2:0] PISO_P3 = 3'd3;
  localparam logic [2:0] PISO_P4 = 3'd4;

  localparam int N_PISOS = 5;

  localparam logic DIR_SUBE = 1'b1;
  localparam logic DIR_BAJA = 1'b0;

endpackage

// File: rtl/planificador_ascensor_temporizador_puerta.sv
// Door dwell timer: loadable down-counter that
// parks at zero and flags it.
module temporizador_puerta #(
  parameter int T_PUERTA = 100,
  parameter int W_T      = $clog2(T_PUERTA + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic cero
);

  localparam logic [W_T-1:0] RECARGA =
    W_T'(T_PUERTA - 1);

  logic [W_T-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= RECARGA;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W_T'(1);
    end
  end

  assign cero = (cnt == '0);

endmodule

// File: rtl/planificador_ascensor.sv
// Collective (SCAN) elevator scheduler for stops PS..P4.
// Moore outputs registered from the next-state decode.
module planificador_ascensor
  import planificador_ascensor_pkg::*;
#(
  parameter int T_PUERTA = 100,
  parameter int W_T      = $clog2(T_PUERTA + 1)
) (
  input  logic       _clk_,
  input  logic       _reset_i,
  input  logic [1:0] solicitud_ps_in,
  input  logic [1:0] solicitud_p1_in,
  input  logic [1:0] solicitud_p2_in,
  input  logic [1:0] solicitud_p3_in,
  input  logic [1:0] solicitud_p4_in,
  input  logic [2:0] piso_actual,
  input  logic       sobrepeso,
  input  logic       puerta,
  output logic       motor_subir,
  output logic       motor_bajar,
  output logic       puerta_abrir,
  output logic       clear_ps,
  output logic       clear_p1,
  output logic       clear_p2,
  output logic       clear_p3,
  output logic       clear_p4,
  output logic       direccion,
  output logic       falla
);

  logic [1:0] est;
  logic [1:0] est_sig;
  logic       dir_sig;
  logic       recarga;
  logic       carga;
  logic       pulso;
  logic       cero;

  logic [1:0]         sol [N_PISOS];
  logic [N_PISOS-1:0] pend;
  logic               invalido;
  logic [2:0]         piso;
  logic               clr_any;
  logic               aqui;
  logic               sube_aqui;
  logic               baja_aqui;
  logic               arriba;
  logic               abajo;

  assign sol[0] = solicitud_ps_in;
  assign sol[1] = solicitud_p1_in;
  assign sol[2] = solicitud_p2_in;
  assign sol[3] = solicitud_p3_in;
  assign sol[4] = solicitud_p4_in;

  assign invalido = (piso_actual > PISO_P4);
  assign piso     = invalido ? PISO_PS : piso_actual;
  assign clr_any  = clear_ps | clear_p1 | clear_p2
                  | clear_p3 | clear_p4;

  // A call on this floor is stale while its clear is in flight
  assign aqui      = pend[piso] & ~clr_any & ~invalido;
  assign sube_aqui = aqui & sol[piso][0];
  assign baja_aqui = aqui & sol[piso][1];

  always_comb begin
    pend   = '0;
    arriba = 1'b0;
    abajo  = 1'b0;
    for (int f = 0; f < N_PISOS; f++) begin
      pend[f] = |sol[f];
      if (pend[f] && (3'(f) > piso)) arriba = 1'b1;
      if (pend[f] && (3'(f) < piso)) abajo  = 1'b1;
    end
  end

  always_comb begin
    est_sig = est;
    dir_sig = direccion;
    recarga = 1'b0;
    if (invalido) begin
      est_sig = REPOSO;
    end else begin
      unique case (1'b1)
        (est == REPOSO): begin
          if (aqui) begin
            est_sig = PUERTA;
          end else if (arriba && (direccion || !abajo)) begin
            dir_sig = DIR_SUBE;
            est_sig = SUBIENDO;
          end else if (abajo) begin
            dir_sig = DIR_BAJA;
            est_sig = BAJANDO;
          end
        end
        (est == SUBIENDO): begin
          if (aqui && (sube_aqui || !arriba)) begin
            est_sig = PUERTA;
          end else if ((piso == PISO_P4) ||
                       (!arriba && !aqui)) begin
            est_sig = REPOSO;
          end
        end
        (est == BAJANDO): begin
          if (aqui && (baja_aqui || !abajo)) begin
            est_sig = PUERTA;
          end else if ((piso == PISO_PS) ||
                       (!abajo && !aqui)) begin
            est_sig = REPOSO;
          end
        end
        (est == PUERTA): begin
          if (aqui || puerta || sobrepeso) begin
            recarga = 1'b1;
          end else if (cero) begin
            est_sig = REPOSO;
          end
        end
      endcase
    end
  end

  assign carga = (est_sig == PUERTA) &&
                 ((est != PUERTA) || recarga);
  assign pulso = (est_sig == PUERTA) &&
                 ((est != PUERTA) || aqui);

  temporizador_puerta #(
    .T_PUERTA(T_PUERTA),
    .W_T     (W_T)
  ) u_tmr (
    .clk  (_clk_),
    .reset(_reset_i),
    .load (carga),
    .en   (est == PUERTA),
    .cero (cero)
  );

  always_ff @(posedge _clk_) begin
    if (_reset_i) begin
      est          <= REPOSO;
      direccion    <= DIR_SUBE;
      motor_subir  <= 1'b0;
      motor_bajar  <= 1'b0;
      puerta_abrir <= 1'b0;
      clear_ps     <= 1'b0;
      clear_p1     <= 1'b0;
      clear_p2     <= 1'b0;
      clear_p3     <= 1'b0;
      clear_p4     <= 1'b0;
      falla        <= 1'b0;
    end else begin
      est          <= est_sig;
      direccion    <= dir_sig;
      motor_subir  <= (est_sig == SUBIENDO);
      motor_bajar  <= (est_sig == BAJANDO);
      puerta_abrir <= (est_sig == PUERTA);
      clear_ps     <= pulso && (piso == PISO_PS);
      clear_p1     <= pulso && (piso == PISO_P1);
      clear_p2     <= pulso && (piso == PISO_P2);
      clear_p3     <= pulso && (piso == PISO_P3);
      clear_p4     <= pulso && (piso == PISO_P4);
      falla        <= invalido;
    end
  end

endmodule

// File: tb/tb_planificador_ascensor.sv
// Bench for planificador_ascensor: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_planificador_ascensor;

  localparam int T = 8;
  localparam int IDLE = 0;
  localparam int UP   = 1;
  localparam int DN   = 2;
  localparam int DOOR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req [5];
  logic [2:0] piso = 3'd0;
  logic       sob = 1'b0;
  logic       pta = 1'b0;

  logic motor_subir, motor_bajar, puerta_abrir;
  logic clear_ps, clear_p1, clear_p2, clear_p3, clear_p4;
  logic direccion, falla;

  always #5 clk = ~clk;

  planificador_ascensor #(.T_PUERTA(T)) dut (
    ._clk_          (clk),
    ._reset_i       (rst),
    .solicitud_ps_in(req[0]),
    .solicitud_p1_in(req[1]),
    .solicitud_p2_in(req[2]),
    .solicitud_p3_in(req[3]),
    .solicitud_p4_in(req[4]),
    .piso_actual    (piso),
    .sobrepeso      (sob),
    .puerta         (pta),
    .motor_subir    (motor_subir),
    .motor_bajar    (motor_bajar),
    .puerta_abrir   (puerta_abrir),
    .clear_ps       (clear_ps),
    .clear_p1       (clear_p1),
    .clear_p2       (clear_p2),
    .clear_p3       (clear_p3),
    .clear_p4       (clear_p4),
    .direccion      (direccion),
    .falla          (falla)
  );

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  // Model of the car: what it is doing and how long the door stays open
  int       m_mode = IDLE;
  int       m_left = 0;
  bit       m_dir  = 1'b1;
  bit [4:0] m_clr  = '0;
  bit       m_falla = 1'b0;

  logic [9:0] dut_vec;
  logic [9:0] mdl_vec;

  assign dut_vec = {motor_subir, motor_bajar, puerta_abrir,
                    clear_p4, clear_p3, clear_p2, clear_p1,
                    clear_ps, direccion, falla};
  assign mdl_vec = {m_mode == UP, m_mode == DN,
                    m_mode == DOOR, m_clr, m_dir, m_falla};

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               n, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (chk_en) chk("cycle", 32'(dut_vec), 32'(mdl_vec));

  task automatic step();
    int nm, nl, p;
    bit nd, nf, here, up, dn;
    bit [4:0] nc;
    nm = m_mode; nl = m_left; nd = m_dir;
    nc = '0; nf = 1'b0;
    if (rst) begin
      nm = IDLE; nl = 0; nd = 1'b1;
    end else if (piso > 3'd4) begin
      nm = IDLE; nf = 1'b1;
    end else begin
      p = int'(piso);
      here = (req[p] != 2'b00) && (m_clr == 5'b0);
      up = 1'b0; dn = 1'b0;
      for (int f = 0; f < 5; f++)
        if (req[f] != 2'b00) begin
          if (f > p) up = 1'b1;
          if (f < p) dn = 1'b1;
        end
      case (m_mode)
        IDLE:
          if (here) begin
            nm = DOOR; nl = T; nc[p] = 1'b1;
          end else if (up && (m_dir || !dn)) begin
            nd = 1'b1; nm = UP;
          end else if (dn) begin
            nd = 1'b0; nm = DN;
          end
        UP:
          if (here && (req[p][0] || !up)) begin
            nm = DOOR; nl = T; nc[p] = 1'b1;
          end else if (p == 4 || (!up && !here)) nm = IDLE;
        DN:
          if (here && (req[p][1] || !dn)) begin
            nm = DOOR; nl = T; nc[p] = 1'b1;
          end else if (p == 0 || (!dn && !here)) nm = IDLE;
        default:
          if (here) begin
            nl = T; nc[p] = 1'b1;
          end else if (pta || sob) nl = T;
          else if (nl == 1) nm = IDLE;
          else nl = nl - 1;
      endcase
    end
    @(posedge clk);
    #1;
    for (int f = 0; f < 5; f++)
      if (m_clr[f]) req[f] = 2'b00;
    m_mode = nm; m_left = nl; m_dir = nd;
    m_clr = nc; m_falla = nf;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int n_ab, n_cl, cnt;

  initial begin
    for (int f = 0; f < 5; f++) req[f] = 2'b00;
    run(2);
    chk_en = 1'b1;
    rst = 1'b0;
    run(20);
    chk("idle_reset", 32'(dut_vec), 32'h002);

    req[3] = 2'b01;
    step();
    chk("call_up", 32'(motor_subir), 1);
    piso = 3'd1; step();
    piso = 3'd2; step();
    piso = 3'd3; step();
    chk("arrive_p3", 32'({motor_subir, puerta_abrir, clear_p3}),
        32'b011);
    n_ab = 0; n_cl = 0;
    for (int i = 0; i < 12; i++) begin
      n_ab += int'(puerta_abrir);
      n_cl += int'(clear_p3);
      step();
    end
    chk("dwell_len", n_ab, T);
    chk("clear_p3_once", n_cl, 1);

    piso = 3'd1;
    req[2] = 2'b10;
    req[4] = 2'b01;
    step();
    piso = 3'd2; step();
    piso = 3'd3; step();
    chk("pass_p2", 32'({motor_subir, puerta_abrir}), 32'b10);
    piso = 3'd4; step();
    chk("stop_p4", 32'({puerta_abrir, clear_p4}), 32'b11);
    for (int i = 0; i < 20 && !motor_bajar; i++) step();
    chk("reverse", 32'({motor_bajar, direccion}), 32'b10);
    piso = 3'd3; step();
    piso = 3'd2; step();
    chk("stop_p2", 32'({puerta_abrir, clear_p2}), 32'b11);
    run(12);

    piso = 3'd1;
    req[1] = 2'b01;
    step();
    pta = 1'b1;
    run(20);
    chk("held_open", 32'(puerta_abrir), 1);
    pta = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (!puerta_abrir) break;
      cnt++;
      step();
    end
    chk("close_after_obst", cnt, T);

    req[1] = 2'b10;
    step();
    sob = 1'b1;
    run(20);
    chk("held_sobrepeso", 32'(puerta_abrir), 1);
    sob = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (!puerta_abrir) break;
      cnt++;
      step();
    end
    chk("close_after_sob", cnt, T);

    req[3] = 2'b01;
    step();
    piso = 3'd6; step();
    chk("falla_on", 32'({motor_subir, falla}), 32'b01);
    run(3);
    piso = 3'd2; step();
    chk("falla_off", 32'({motor_subir, falla}), 32'b10);
    piso = 3'd3; step();
    run(12);

    req[0] = 2'b10;
    step();
    chk("going_down", 32'(motor_bajar), 1);
    piso = 3'd2; step();
    rst = 1'b1; step();
    chk("rst_travel", 32'(dut_vec), 32'h002);
    rst = 1'b0; step();
    piso = 3'd1; step();
    piso = 3'd0; step();
    chk("stop_ps", 32'({puerta_abrir, clear_ps}), 32'b11);
    run(3);
    rst = 1'b1; step();
    chk("rst_dwell", 32'(dut_vec), 32'h002);
    rst = 1'b0;
    run(5);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
